vid_access_arbiter: RTL and testbench
=====================================

// Module: vid_access_arbiter
// PURPOSE
//  Shares the single vid-addressed access port of a compiled engine (read/vid/in/out/wait) among NREQ requesters.
//  Typical requesters: host bridge and on-board stimulus/debug scanner.
//  Serialises one access at a time; round-robin arbitration; honours the engine's wait; returns read data per requester.
//  Sits in the FPGA top between the requesters and the engine instance.
// PARAMETERS
//  NREQ     2    number of requesters (2..8)
//  VID_W    14   variable-id width
//  DATA_W   32   data width
//  TIMEOUT  255  max WAIT cycles before abort (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1             clock; all logic rising-edge
//  rst        in   1             synchronous reset, active-high
//  req_valid  in   NREQ          requester i has an access pending
//  req_write  in   NREQ          1=write, 0=read (per requester)
//  req_vid    in   NREQ*VID_W    target variable id, slice i
//  req_wdata  in   NREQ*DATA_W   write data, slice i
//  req_ready  out  NREQ          one-hot accept pulse (combinational in IDLE)
//  rsp_valid  out  NREQ          one-hot completion pulse, 1 cycle
//  rsp_rdata  out  DATA_W        read data, valid with rsp_valid
//  rsp_err    out  1             access aborted by timeout, valid with rsp_valid
//  busy       out  1             state != IDLE
//  eng_read   out  1             engine read strobe
//  eng_write  out  1             engine write strobe
//  eng_vid    out  VID_W         engine variable id
//  eng_in     out  DATA_W        engine write data
//  eng_out    in   DATA_W        engine read data
//  eng_wait   in   1             engine busy; access incomplete while high
// BEHAVIOUR
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE
//   - Winner = first valid requester at or after priority pointer ptr, wrapping modulo NREQ.
//   - Winner's req_ready=1 this cycle; its write/vid/wdata latched; -> ISSUE.
//   - No valid requester: stay IDLE, req_ready=0.
//  ISSUE
//   - Exactly one of eng_read/eng_write high for exactly 1 cycle; eng_vid/eng_in driven from latch; -> WAIT.
//  WAIT
//   - eng_vid/eng_in held stable; strobes low.
//   - eng_wait==0: capture eng_out into rsp_rdata (reads only; writes leave rsp_rdata=0); -> RESP.
//   - eng_wait==1: remain in WAIT.
//  RESP
//   - rsp_valid[winner]=1 for one cycle; ptr <= (winner+1) mod NREQ; -> IDLE.
//  Latency: accept at T, strobe T+1, earliest sample T+2, rsp_valid T+3; next accept earliest T+4.
//  Requesters hold req_* until req_ready.
//  Deasserting req_valid before grant withdraws the request; no effect after grant.
//  Simultaneous requests: strict rotation from ptr; starvation-free (any valid requester is served within NREQ grants).
//  rsp_rdata/rsp_err hold last value until next RESP.
//  Reset (any state, incl. mid-WAIT):
//   - next edge -> IDLE, ptr=0.
//   - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, busy, eng_read, eng_write, eng_vid, eng_in.
//   - In-flight access dropped with no response.
//  All widths exact; ptr is clog2(NREQ) bits; wrap at NREQ-1 -> 0 (for non-power-of-2 NREQ too).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - WAIT counter cleared on entry to WAIT; increments each cycle eng_wait==1.
//   - Counter reaching TIMEOUT -> RESP with rsp_err=1, rsp_rdata=0.
//   - eng_wait falling on the same cycle as count==TIMEOUT counts as success (err=0).
//  ARB_TIMEOUT_EN undefined: no counter; rsp_err tied 0; WAIT unbounded.
// STRUCTURE
//  Package vid_arb_pkg:
//   - state enum {IDLE, ISSUE, WAIT, RESP}.
//   - default VID_W/DATA_W constants.
//   - clog2 helper.
//  Sub-module rr_pick: NREQ-wide round-robin picker (valid vector, ptr -> one-hot grant + index); purely combinational.
//  FSM, latches and timeout counter in vid_access_arbiter.
// TESTING
//  1. Single read: NREQ=2, req0 read vid=0x005, eng_wait=0, eng_out=0xDEADBEEF
//     -> eng_read pulse T+1, eng_vid=0x005, rsp_valid=01 T+3, rsp_rdata=0xDEADBEEF.
//  2. Contention: both valid, ptr=0 -> grant order 0,1,0,1 over 4 accesses; each rsp_valid matches granted requester.
//  3. Wait stall: eng_wait high 10 cycles after write vid=0x3FFF data=0x1
//     -> eng_vid/eng_in stable throughout, rsp_valid 10 cycles late, rsp_err=0.
//  4. Reset mid-WAIT: assert rst during WAIT
//     -> next cycle busy=0, all eng_* =0, no rsp_valid; next request granted to requester 0.
//  5. ARB_TIMEOUT_EN, TIMEOUT=4: eng_wait stuck high -> rsp_err=1, rsp_rdata=0 after 4 WAIT cycles.
//     Without macro: still busy after 100 cycles.
//  6. Withdrawal: req1 drops valid before grant -> never granted, no rsp_valid[1].

Source files
------------

// File: rtl/vid_arb_pkg.sv
// vid_arb_pkg: shared state encoding, default widths and clog2 helper for the vid access arbiter.
package vid_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int VID_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first valid requester at or after ptr, wrapping at NREQ.
module rr_pick import vid_arb_pkg::*; #(
    parameter int NREQ = 2,
    parameter int PW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);
    logic [PW-1:0] j;
    // Scan from farthest to nearest so the candidate closest to ptr is assigned last.
    always_comb begin
        idx_o = '0;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = PW'((int'(ptr_i) + k) % NREQ);
            if (valid_i[j]) idx_o = j;
        end
    end
    assign any_o = |valid_i;
    assign grant_o = any_o ? NREQ'(1) << idx_o : '0;
endmodule

// File: rtl/vid_access_arbiter.sv
// vid_access_arbiter: serialises NREQ requesters onto one engine vid access port, round-robin.
// Define ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT stalled cycles with rsp_err.
module vid_access_arbiter import vid_arb_pkg::*; #(
    parameter int NREQ    = 2,
    parameter int VID_W   = VID_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*VID_W-1:0]    req_vid,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     eng_read,
    output logic                     eng_write,
    output logic [VID_W-1:0]         eng_vid,
    output logic [DATA_W-1:0]        eng_in,
    input  logic [DATA_W-1:0]        eng_out,
    input  logic                     eng_wait
);
    localparam int PW = clog2(NREQ);
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_err
        $error("vid_access_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end
    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d, win_q, win_d, pick_idx;
    logic [NREQ-1:0]     pick_grant;
    logic                pick_any;
    logic                wr_q, wr_d;
    logic [VID_W-1:0]    vid_q, vid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
`endif
    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid_i(req_valid),
        .ptr_i  (ptr_q),
        .grant_o(pick_grant),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        wr_d    = wr_q;
        vid_d   = vid_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: if (pick_any) begin
                state_d = ISSUE;
                win_d   = pick_idx;
                wr_d    = req_write[pick_idx];
                vid_d   = req_vid[pick_idx*VID_W +: VID_W];
                wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (!eng_wait) begin
                state_d = RESP;
                rdata_d = wr_q ? '0 : eng_out;
`ifdef ARB_TIMEOUT_EN
                err_d   = 1'b0;
            end else if (cnt_q == CW'(TIMEOUT)) begin
                state_d = RESP;
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
`endif
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            wr_q    <= 1'b0;
            vid_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            vid_q   <= vid_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end
    // Grant is combinational in IDLE but suppressed while reset is held.
    assign req_ready = (state_q == IDLE && !rst) ? pick_grant : '0;
    assign rsp_valid = (state_q == RESP) ? NREQ'(1) << win_q : '0;
    assign rsp_rdata = rdata_q;
`ifdef ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign busy      = state_q != IDLE;
    assign eng_read  = state_q == ISSUE && !wr_q;
    assign eng_write = state_q == ISSUE && wr_q;
    assign eng_vid   = vid_q;
    assign eng_in    = wdata_q;
endmodule

// File: tb/tb_vid_access_arbiter.sv
// tb_vid_access_arbiter: transaction-level model of grant rotation and response timing, plus directed scenarios.
module tb_vid_access_arbiter;
    localparam int NREQ = 2, VID_W = 14, DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 10;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
    logic [NREQ*VID_W-1:0] req_vid = '0;
    logic [NREQ*DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0] rsp_rdata, eng_in, eng_out = '0;
    logic [VID_W-1:0] eng_vid;
    logic rsp_err, busy, eng_read, eng_write, eng_wait = 1'b0;
    always #5 clk = ~clk;
    vid_access_arbiter #(.NREQ(NREQ), .VID_W(VID_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_vid(req_vid),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .eng_read(eng_read), .eng_write(eng_write), .eng_vid(eng_vid),
        .eng_in(eng_in), .eng_out(eng_out), .eng_wait(eng_wait)
    );
    int n_chk = 0, n_fail = 0, cyc = 0;
    int want[NREQ] = '{0, 0}, gcnt[NREQ] = '{0, 0}, rspc[NREQ] = '{0, 0};
    int gq[$];
    bit chk_en = 1'b1;
    int acc = -1, done = -1, mptr = 0, win = 0, lat = 0, p_w;
    logic mwr = 1'b0;
    logic [VID_W-1:0] mvid = '0;
    logic [DATA_W-1:0] mwd = '0, mrd = '0, pend_rd = '0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction
    // Model: an accepted access strobes the next cycle, completes on the first cycle from
    // accept+2 with eng_wait low, and responds one cycle after that.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc = -1; done = -1; mptr = 0; mrd = '0;
        end else begin
            p_w = pick(req_valid, mptr);
            if (done >= 0 && cyc == done + 1) mrd = pend_rd;
            if (chk_en) begin
                chk("busy", 64'(busy), 64'(acc >= 0));
                chk("req_ready", 64'(req_ready), (acc < 0 && p_w >= 0) ? 64'(1) << p_w : 64'(0));
                chk("eng_read", 64'(eng_read), 64'(acc >= 0 && cyc == acc + 1 && !mwr));
                chk("eng_write", 64'(eng_write), 64'(acc >= 0 && cyc == acc + 1 && mwr));
                if (acc >= 0 && (done < 0 || cyc <= done)) begin
                    chk("eng_vid", 64'(eng_vid), 64'(mvid));
                    chk("eng_in", 64'(eng_in), 64'(mwd));
                end
                chk("rsp_valid", 64'(rsp_valid), (done >= 0 && cyc == done + 1) ? 64'(1) << win : 64'(0));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mrd));
                chk("rsp_err", 64'(rsp_err), 64'(0));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin gcnt[i]++; gq.push_back(i); end
                if (rsp_valid[i]) rspc[i]++;
            end
            if (acc < 0 && p_w >= 0) begin
                acc = cyc; win = p_w; mwr = req_write[p_w];
                mvid = req_vid[p_w*VID_W +: VID_W]; mwd = req_wdata[p_w*DATA_W +: DATA_W];
            end else if (acc >= 0 && done < 0 && cyc >= acc + 2 && !eng_wait) begin
                done = cyc; pend_rd = mwr ? '0 : eng_out;
            end else if (done >= 0 && cyc == done + 1) begin
                lat = cyc - acc; mptr = (win + 1) % NREQ; acc = -1; done = -1;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) req_valid[i] = want[i] > gcnt[i];
    endtask
    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask
    task automatic wait_gnt(input int i);
        int g = gcnt[i];
        for (int k = 0; k < 20 && gcnt[i] == g; k++) tick();
        if (gcnt[i] == g) chk("grant_timeout", 64'(0), 64'(1));
    endtask
    task automatic set_req(input int i, input logic wr, input logic [VID_W-1:0] v, input logic [DATA_W-1:0] d);
        req_write[i] = wr;
        req_vid[i*VID_W +: VID_W] = v;
        req_wdata[i*DATA_W +: DATA_W] = d;
        want[i]++;
    endtask
    int r0, r1, g1;
    initial begin
        run(3);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rdata", 64'(rsp_rdata), 0);
        chk("rst_eng", {eng_read, eng_write, 16'(eng_vid), eng_in}, 0);
        rst = 1'b0;
        // Contention from ptr=0: strict alternation.
        eng_out = 32'h1234_5678;
        set_req(0, 1'b0, 14'h011, 32'h0); set_req(0, 1'b0, 14'h011, 32'h0);
        set_req(1, 1'b0, 14'h022, 32'h0); set_req(1, 1'b0, 14'h022, 32'h0);
        run(20);
        chk("contention_count", 64'(gq.size()), 4);
        if (gq.size() == 4) begin
            chk("order0", 64'(gq[0]), 0); chk("order1", 64'(gq[1]), 1);
            chk("order2", 64'(gq[2]), 0); chk("order3", 64'(gq[3]), 1);
        end
        chk("contention_rsp", 64'(rspc[0] * 10 + rspc[1]), 22);
        // Single read.
        eng_out = 32'hDEAD_BEEF;
        r0 = rspc[0];
        set_req(0, 1'b0, 14'h005, 32'h0);
        run(6);
        chk("read_latency", 64'(lat), 3);
        chk("read_rdata", 64'(rsp_rdata), 64'h DEAD_BEEF);
        chk("read_rsp_count", 64'(rspc[0] - r0), 1);
        // Write stalled by eng_wait.
        eng_wait = 1'b1;
        set_req(0, 1'b1, 14'h3FFF, 32'h1);
        wait_gnt(0);
        run(STALL + 1);
        eng_wait = 1'b0;
        run(4);
        chk("stall_latency", 64'(lat), 64'(3 + STALL));
        chk("write_rdata", 64'(rsp_rdata), 0);
        chk("write_err", 64'(rsp_err), 0);
        // Withdrawal of requester 1 while requester 0 is in flight.
        g1 = gcnt[1]; r1 = rspc[1]; r0 = rspc[0];
        eng_wait = 1'b1;
        set_req(0, 1'b1, 14'h007, 32'hA5A5_0000);
        wait_gnt(0);
        set_req(1, 1'b0, 14'h123, 32'h0);
        run(2);
        want[1] = gcnt[1];
        tick();
        eng_wait = 1'b0;
        run(10);
        chk("withdraw_grant", 64'(gcnt[1] - g1), 0);
        chk("withdraw_rsp", 64'(rspc[1] - r1), 0);
        chk("withdraw_other_rsp", 64'(rspc[0] - r0), 1);
        // Reset mid-WAIT with ptr=1 and requester 1 in flight.
        set_req(0, 1'b0, 14'h001, 32'h0);
        run(6);
        eng_wait = 1'b1;
        set_req(1, 1'b0, 14'h002, 32'h0);
        wait_gnt(1);
        run(3);
        rst = 1'b1; eng_wait = 1'b0;
        want[0] = gcnt[0]; want[1] = gcnt[1];
        tick();
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_eng", {eng_read, eng_write, 16'(eng_vid), eng_in}, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        r1 = rspc[1];
        rst = 1'b0;
        gq.delete();
        set_req(0, 1'b0, 14'h010, 32'h0);
        set_req(1, 1'b0, 14'h020, 32'h0);
        run(12);
        chk("post_rst_first", (gq.size() > 0) ? 64'(gq[0]) : 64'hFF, 0);
        chk("post_rst_rsp1", 64'(rspc[1] - r1), 1);
        // Engine stuck in wait.
        eng_wait = 1'b1; eng_out = 32'hCAFE_F00D;
        r0 = rspc[0];
`ifdef ARB_TIMEOUT_EN
        chk_en = 1'b0;
        set_req(0, 1'b0, 14'h0AA, 32'h0);
        for (int k = 0; k < 50 && rspc[0] == r0; k++) tick();
        chk("timeout_rsp", 64'(rspc[0] - r0), 1);
        chk("timeout_err", 64'(rsp_err), 1);
        chk("timeout_rdata", 64'(rsp_rdata), 0);
`else
        set_req(0, 1'b0, 14'h0AA, 32'h0);
        run(100);
        chk("stuck_busy", 64'(busy), 1);
        chk("stuck_no_rsp", 64'(rspc[0] - r0), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
